// File: rtl/segment7_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver and its decoder.
// Holds the hex glyph table, segment bit positions and small helpers.
package segment7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [6:0] GLYPH_0 = 7'b1111110;
  localparam logic [6:0] GLYPH_1 = 7'b0110000;
  localparam logic [6:0] GLYPH_2 = 7'b1101101;
  localparam logic [6:0] GLYPH_3 = 7'b1111001;
  localparam logic [6:0] GLYPH_4 = 7'b0110011;
  localparam logic [6:0] GLYPH_5 = 7'b1011011;
  localparam logic [6:0] GLYPH_6 = 7'b1011111;
  localparam logic [6:0] GLYPH_7 = 7'b1110000;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1111011;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b0011111;
  localparam logic [6:0] GLYPH_C = 7'b1001110;
  localparam logic [6:0] GLYPH_D = 7'b0111101;
  localparam logic [6:0] GLYPH_E = 7'b1001111;
  localparam logic [6:0] GLYPH_F = 7'b1000111;

  // True when exactly one digit select is active.
  function automatic logic is_onehot4(input logic [3:0] sel);
    return (sel != 4'b0000) && ((sel & (sel - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/seg7_pattern_to_hex.sv
// Combinational reverse glyph lookup: 7-bit segment pattern to hex nibble.
// Patterns outside the glyph table report legal=0 with nibble 0.
module seg7_pattern_to_hex
  import segment7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       legal,
  output logic [3:0] nibble
);

  // Glyph table lookup
  always_comb begin
    legal  = 1'b1;
    nibble = 4'h0;
    case (pattern)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: begin
        legal  = 1'b0;
        nibble = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/segment7_decoder.sv
// Receive-side monitor for a multiplexed 7-segment bus: debounces the sampled
// anode/segment lines, decodes each digit and reassembles complete 16-bit frames.
module segment7_decoder
  import segment7_pkg::*;
#(
  parameter int STABLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  anodes,
  input  logic [6:0]  segments,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        pattern_err,
  output logic        anode_err
);

  localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

  logic [10:0] sync1_r, sync2_r, last_r;
  logic [7:0]  run_r, run_s;
  logic        accept_s;
  logic [3:0]  anode_s;
  logic [6:0]  pattern_s;
  logic        legal_s;
  logic [3:0]  nibble_s;

  logic [NUM_DIGITS-1:0][3:0] shadow_r, shadow_s;
  logic [NUM_DIGITS-1:0]      seen_r, seen_s;
  logic [15:0] data_r, data_s;
  logic        dv_r, dv_s, perr_r, perr_s, aerr_r, aerr_s;

  assign anode_s   = sync2_r[10:7];
  assign pattern_s = sync2_r[6:0];

  seg7_pattern_to_hex u_p2h (
    .pattern (pattern_s),
    .legal   (legal_s),
    .nibble  (nibble_s)
  );

  // Stable-run length; saturates so a long hold never re-accepts
  always_comb begin
    if (sync2_r != last_r) begin
      run_s = 8'd1;
    end else if (run_r == 8'd255) begin
      run_s = 8'd255;
    end else begin
      run_s = run_r + 8'd1;
    end
  end

  assign accept_s = (run_s == STABLE_W);

  // Frame assembly on each accepted sample
  always_comb begin
    shadow_s = shadow_r;
    seen_s   = seen_r;
    data_s   = data_r;
    dv_s     = 1'b0;
    perr_s   = 1'b0;
    aerr_s   = 1'b0;
    if (!accept_s || anode_s == 4'b0000) begin
      dv_s = 1'b0;
    end else if (!is_onehot4(anode_s)) begin
      aerr_s = 1'b1;
    end else if (!legal_s) begin
      perr_s = 1'b1;
      seen_s = seen_r & ~anode_s;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (anode_s[k]) begin
          shadow_s[k] = nibble_s;
        end else begin
          shadow_s[k] = shadow_r[k];
        end
      end
      seen_s = seen_r | anode_s;
      if (seen_s == 4'b1111) begin
        data_s = shadow_s;
        dv_s   = 1'b1;
        seen_s = 4'b0000;
      end else begin
        dv_s = 1'b0;
      end
    end
  end

  // Input synchronizer and run tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 11'd0;
      sync2_r <= 11'd0;
      last_r  <= 11'd0;
      run_r   <= 8'd0;
    end else begin
      sync1_r <= {anodes, segments};
      sync2_r <= sync1_r;
      last_r  <= sync2_r;
      run_r   <= run_s;
    end
  end

  // Frame state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r <= '0;
      seen_r   <= 4'b0000;
      data_r   <= 16'h0000;
      dv_r     <= 1'b0;
      perr_r   <= 1'b0;
      aerr_r   <= 1'b0;
    end else begin
      shadow_r <= shadow_s;
      seen_r   <= seen_s;
      data_r   <= data_s;
      dv_r     <= dv_s;
      perr_r   <= perr_s;
      aerr_r   <= aerr_s;
    end
  end

  assign data        = data_r;
  assign data_valid  = dv_r;
  assign pattern_err = perr_r;
  assign anode_err   = aerr_r;

endmodule

// File: tb/tb_segment7_decoder.sv
// Self-checking bench for segment7_decoder: one instance debounced over 1 cycle
// with a data scoreboard, one over 3 cycles for glitch and saturation behaviour.
module tb_segment7_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  an1 = 4'b0000, an3 = 4'b0000;
  logic [6:0]  sg1 = 7'b0000000, sg3 = 7'b0000000;
  logic [15:0] data1, data3;
  logic        dv1, pe1, ae1, dv3, pe3, ae3;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int dv1_cnt = 0, pe1_cnt = 0, ae1_cnt = 0;
  int dv3_cnt = 0, pe3_cnt = 0, ae3_cnt = 0;
  int dv_last = 0, dv_prev = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  segment7_decoder #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .anodes(an1), .segments(sg1),
    .data(data1), .data_valid(dv1), .pattern_err(pe1), .anode_err(ae1)
  );

  segment7_decoder #(.STABLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .anodes(an3), .segments(sg3),
    .data(data3), .data_valid(dv3), .pattern_err(pe3), .anode_err(ae3)
  );

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
          7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
          7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
          7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    return t[n];
  endfunction

  // Scoreboard: every data_valid on dut1 pops one expected word
  always @(negedge clk) begin
    logic [15:0] e;
    cyc++;
    if (dv1) begin
      dv1_cnt++;
      dv_prev = dv_last;
      dv_last = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_dv: data=%h, no word expected", data1);
      end else begin
        e = exp_q.pop_front();
        if (data1 !== e) $display("FAIL sb_data: got %h expected %h", data1, e);
        else passes++;
      end
    end
    if (pe1) pe1_cnt++;
    if (ae1) ae1_cnt++;
    if (dv3) dv3_cnt++;
    if (pe3) pe3_cnt++;
    if (ae3) ae3_cnt++;
  end

  task automatic present(input logic [3:0] a, input logic [6:0] s);
    an1 = a;
    sg1 = s;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) present(4'b0000, 7'b0000000);
  endtask

  task automatic step3(input logic [3:0] a, input logic [6:0] s, input int n);
    an3 = a;
    sg3 = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({data1, dv1, pe1, ae1} !== 19'd0) $display("FAIL reset_dut1: got %h expected 0", {data1, dv1, pe1, ae1});
    else passes++;
    checks++;
    if ({data3, dv3, pe3, ae3} !== 19'd0) $display("FAIL reset_dut3: got %h expected 0", {data3, dv3, pe3, ae3});
    else passes++;
    rst_n = 1'b1;
    drain(3);
  endtask

  task automatic test_basic;
    int b = dv1_cnt;
    exp_q.push_back(16'hFA43);
    present(4'b0001, 7'b1111001);
    present(4'b0010, 7'b0110011);
    present(4'b0100, 7'b1110111);
    present(4'b1000, 7'b1000111);
    present(4'b0000, 7'b0000000);
    checks++;
    if (dv1 !== 1'b0) $display("FAIL basic_dv_early: got %b expected 0", dv1);
    else passes++;
    present(4'b0000, 7'b0000000);
    checks++;
    if (dv1 !== 1'b1 || data1 !== 16'hFA43) $display("FAIL basic_latency: dv=%b data=%h expected 1/fa43", dv1, data1);
    else passes++;
    drain(3);
    checks++;
    if (dv1_cnt - b !== 1) $display("FAIL basic_pulses: got %0d expected 1", dv1_cnt - b);
    else passes++;
  endtask

  task automatic test_loopback;
    int b = dv1_cnt, bp = pe1_cnt, ba = ae1_cnt;
    logic [15:0] w = 16'h1234;
    for (int f = 0; f < 6; f++) begin
      exp_q.push_back(w);
      for (int k = 0; k < 4; k++) begin
        logic [3:0] sel;
        sel = 4'b0001 << k;
        present(sel, glyph(w[4*k +: 4]));
      end
    end
    drain(3);
    checks++;
    if (dv1_cnt - b !== 6) $display("FAIL loop_frames: got %0d expected 6", dv1_cnt - b);
    else passes++;
    checks++;
    if (dv_last - dv_prev !== 4) $display("FAIL loop_period: got %0d expected 4", dv_last - dv_prev);
    else passes++;
    checks++;
    if (pe1_cnt !== bp || ae1_cnt !== ba) $display("FAIL loop_errs: got pe=%0d ae=%0d expected 0/0", pe1_cnt - bp, ae1_cnt - ba);
    else passes++;
  endtask

  task automatic test_pattern_err;
    int b = dv1_cnt, bp = pe1_cnt;
    present(4'b0001, glyph(4'h8));
    present(4'b0010, glyph(4'h7));
    present(4'b0100, 7'b0000001);
    present(4'b1000, glyph(4'h9));
    drain(3);
    checks++;
    if (pe1_cnt - bp !== 1) $display("FAIL perr_pulse: got %0d expected 1", pe1_cnt - bp);
    else passes++;
    checks++;
    if (dv1_cnt !== b) $display("FAIL perr_no_dv: got %0d expected 0", dv1_cnt - b);
    else passes++;
    exp_q.push_back(16'h9578);
    present(4'b0100, glyph(4'h5));
    drain(3);
    checks++;
    if (dv1_cnt - b !== 1 || data1[11:8] !== 4'h5) $display("FAIL perr_recover: dv=%0d nib=%h expected 1/5", dv1_cnt - b, data1[11:8]);
    else passes++;
  endtask

  task automatic test_anode_err;
    int b = dv1_cnt, ba = ae1_cnt, bp = pe1_cnt;
    present(4'b0001, glyph(4'h1));
    present(4'b0011, glyph(4'hF));
    present(4'b0000, glyph(4'h8));
    drain(3);
    checks++;
    if (ae1_cnt - ba !== 1 || pe1_cnt !== bp) $display("FAIL aerr_pulse: ae=%0d pe=%0d expected 1/0", ae1_cnt - ba, pe1_cnt - bp);
    else passes++;
    present(4'b0100, glyph(4'h2));
    present(4'b1000, glyph(4'h3));
    drain(3);
    checks++;
    if (dv1_cnt !== b) $display("FAIL aerr_seen: got %0d dv expected 0", dv1_cnt - b);
    else passes++;
    exp_q.push_back(16'h3241);
    present(4'b0010, glyph(4'h4));
    drain(3);
    checks++;
    if (dv1_cnt - b !== 1) $display("FAIL aerr_frame: got %0d expected 1", dv1_cnt - b);
    else passes++;
  endtask

  task automatic test_stable3;
    int ba = ae3_cnt, bp = pe3_cnt;
    step3(4'b0011, glyph(4'h1), 1);
    step3(4'b0000, 7'b0000000, 6);
    step3(4'b0011, glyph(4'h1), 2);
    step3(4'b0000, 7'b0000000, 6);
    checks++;
    if (ae3_cnt !== ba) $display("FAIL s3_glitch: got %0d pulses expected 0", ae3_cnt - ba);
    else passes++;
    step3(4'b0011, glyph(4'h1), 3);
    step3(4'b0000, 7'b0000000, 6);
    checks++;
    if (ae3_cnt - ba !== 1) $display("FAIL s3_hold3: got %0d pulses expected 1", ae3_cnt - ba);
    else passes++;
    step3(4'b0001, 7'b0000001, 300);
    step3(4'b0000, 7'b0000000, 6);
    checks++;
    if (pe3_cnt - bp !== 1) $display("FAIL s3_hold300: got %0d pulses expected 1", pe3_cnt - bp);
    else passes++;
    step3(4'b0001, glyph(4'hA), 3);
    step3(4'b0010, glyph(4'hB), 3);
    step3(4'b0100, glyph(4'hC), 3);
    step3(4'b1000, glyph(4'hD), 3);
    step3(4'b0000, 7'b0000000, 6);
    checks++;
    if (dv3_cnt !== 1 || data3 !== 16'hDCBA) $display("FAIL s3_frame: dv=%0d data=%h expected 1/dcba", dv3_cnt, data3);
    else passes++;
  endtask

  task automatic test_reset_midframe;
    int b;
    present(4'b0001, glyph(4'h6));
    present(4'b0010, glyph(4'h7));
    drain(3);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data1, dv1, pe1, ae1} !== 19'd0) $display("FAIL rst_mid_outputs: got %h expected 0", {data1, dv1, pe1, ae1});
    else passes++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drain(2);
    b = dv1_cnt;
    present(4'b0100, glyph(4'h8));
    present(4'b1000, glyph(4'h9));
    drain(3);
    checks++;
    if (dv1_cnt !== b || data1 !== 16'h0000) $display("FAIL rst_mid_partial: dv=%0d data=%h expected 0/0000", dv1_cnt - b, data1);
    else passes++;
    exp_q.push_back(16'h98CB);
    present(4'b0001, glyph(4'hB));
    present(4'b0010, glyph(4'hC));
    drain(3);
    checks++;
    if (dv1_cnt - b !== 1) $display("FAIL rst_mid_frame: got %0d expected 1", dv1_cnt - b);
    else passes++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_loopback;
    test_pattern_err;
    test_anode_err;
    test_stable3;
    test_reset_midframe;
    checks++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d words pending expected 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
